// File: rtl/exe_stage_pkg.sv
// Shared definitions for the EXE stage: ALU command codes, shift types,
// status bit positions, multiplier FSM states and a rotate helper.
package exe_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int ST_N = 3;
  localparam int ST_Z = 2;
  localparam int ST_C = 1;
  localparam int ST_V = 0;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  // Rotate right; a zero amount returns the value unchanged.
  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] n);
    return (v >> n) | (v << (6'd32 - {1'b0, n}));
  endfunction

endpackage

// File: rtl/exe_stage_val2_gen.sv
// Second-operand generator: rotated 8-bit immediate, 12-bit memory offset,
// or the shifted register operand.
module val2_gen
  import exe_pkg::*;
(
  input  logic [31:0] val_rm,
  input  logic [11:0] shift_operand,
  input  logic        imm,
  input  logic        mem_en,
  output logic [31:0] val2
);

  logic [4:0] amt;

  assign amt = shift_operand[11:7];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    val2 = val_rm;
    if (imm) begin
      val2 = ror32({24'b0, shift_operand[7:0]}, {shift_operand[11:8], 1'b0});
    end else if (mem_en) begin
      val2 = {20'b0, shift_operand};
    end else begin
      case (shift_operand[6:5])
        SH_LSL:  val2 = val_rm << amt;
        SH_LSR:  val2 = val_rm >> amt;
        SH_ASR:  val2 = $signed(val_rm) >>> amt;
        SH_ROR:  val2 = ror32(val_rm, amt);
        default: val2 = val_rm;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: Val2, ALU, branch target, NZCV register and the optional
// iterative multiplier, built only when EXE_STAGE_MUL_EN is defined.
module exe_stage
  import exe_pkg::*;
#(
  parameter int MUL_BITS_PER_CYC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        wb_en_i,
  input  logic        mem_r_en_i,
  input  logic        mem_w_en_i,
  input  logic [3:0]  exe_cmd_i,
  input  logic        b_i,
  input  logic        s_i,
  input  logic [31:0] val_rn_i,
  input  logic [31:0] val_rm_i,
  input  logic [11:0] shift_operand_i,
  input  logic        imm_i,
  input  logic [23:0] signed_imm_24_i,
  input  logic [3:0]  dest_i,
  output logic [31:0] alu_result_o,
  output logic [31:0] br_addr_o,
  output logic        branch_taken_o,
  output logic [3:0]  status_o,
  output logic        wb_en_o,
  output logic        mem_r_en_o,
  output logic        mem_w_en_o,
  output logic [3:0]  dest_o,
  output logic [31:0] st_val_o,
  output logic        stall_o
);

  logic [31:0] val2;
  logic [31:0] alu_res;
  logic [31:0] b_op;
  logic [32:0] sum;
  logic        cin;
  logic        arith;
  logic        legal;
  logic        stall;
  logic        upd;
  logic [3:0]  status_q;

  if (MUL_BITS_PER_CYC < 1 || (32 % MUL_BITS_PER_CYC) != 0) begin : g_bad_mul_bits
    $error("MUL_BITS_PER_CYC must divide 32");
  end

  val2_gen u_val2_gen (
    .val_rm        (val_rm_i),
    .shift_operand (shift_operand_i),
    .imm           (imm_i),
    .mem_en        (mem_r_en_i | mem_w_en_i),
    .val2          (val2)
  );

`ifdef EXE_STAGE_MUL_EN
  localparam int MUL_CYCLES = 32 / MUL_BITS_PER_CYC;

  mul_state_t  state;
  logic [31:0] mul_acc;
  logic [31:0] mul_rn;
  logic [31:0] mul_rm;
  logic [5:0]  mul_cnt;

  // Shift-and-add: each BUSY cycle retires the low chunk of mul_rm against mul_rn.
  // NOTE: sequential state uses non-blocking assignments only; the datapath registers
  // are reset as well so an aborted multiply leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= MUL_IDLE;
      mul_acc <= '0;
      mul_rn  <= '0;
      mul_rm  <= '0;
      mul_cnt <= '0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (exe_cmd_i == CMD_MUL) begin
            mul_rn  <= val_rn_i;
            mul_rm  <= val_rm_i;
            mul_acc <= '0;
            mul_cnt <= '0;
            state   <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          mul_acc <= mul_acc + mul_rn * 32'(mul_rm[MUL_BITS_PER_CYC-1:0]);
          mul_rn  <= mul_rn << MUL_BITS_PER_CYC;
          mul_rm  <= mul_rm >> MUL_BITS_PER_CYC;
          mul_cnt <= mul_cnt + 6'd1;
          if (mul_cnt == 6'(MUL_CYCLES - 1)) begin
            state <= MUL_DONE;
          end
        end
        MUL_DONE: state <= MUL_IDLE;
        default:  state <= MUL_IDLE;
      endcase
    end
  end

  // Stall starts in the same cycle the MUL arrives so the front end freezes at once.
  assign stall = ~rst & (((state == MUL_IDLE) & (exe_cmd_i == CMD_MUL)) | (state == MUL_BUSY));
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    b_op    = val2;
    cin     = 1'b0;
    arith   = 1'b0;
    legal   = 1'b1;
    alu_res = '0;
    case (exe_cmd_i)
      CMD_MOV: alu_res = val2;
      CMD_MVN: alu_res = ~val2;
      CMD_ADD: arith = 1'b1;
      CMD_ADC: begin
        arith = 1'b1;
        cin   = status_q[ST_C];
      end
      CMD_SUB: begin
        arith = 1'b1;
        b_op  = ~val2;
        cin   = 1'b1;
      end
      CMD_SBC: begin
        arith = 1'b1;
        b_op  = ~val2;
        cin   = status_q[ST_C];
      end
      CMD_AND: alu_res = val_rn_i & val2;
      CMD_ORR: alu_res = val_rn_i | val2;
      CMD_EOR: alu_res = val_rn_i ^ val2;
`ifdef EXE_STAGE_MUL_EN
      CMD_MUL: alu_res = mul_acc;
`endif
      default: legal = 1'b0;
    endcase
    // Subtraction is addition of the inverted operand, so C is the inverted borrow.
    sum = {1'b0, val_rn_i} + {1'b0, b_op} + {32'b0, cin};
    if (arith) begin
      alu_res = sum[31:0];
    end
  end

  assign upd = s_i & ~b_i & legal & ~stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= '0;
    end else if (upd) begin
      status_q[ST_N] <= alu_res[31];
      status_q[ST_Z] <= (alu_res == '0);
      if (arith) begin
        status_q[ST_C] <= sum[32];
        status_q[ST_V] <= (val_rn_i[31] == b_op[31]) & (sum[31] != val_rn_i[31]);
      end
    end
  end

  assign alu_result_o   = alu_res;
  assign br_addr_o      = pc_i + {{6{signed_imm_24_i[23]}}, signed_imm_24_i, 2'b00};
  assign branch_taken_o = b_i;
  assign status_o       = status_q;
  assign wb_en_o        = wb_en_i & ~stall;
  assign mem_r_en_o     = mem_r_en_i & ~stall;
  assign mem_w_en_o     = mem_w_en_i & ~stall;
  assign dest_o         = dest_i;
  assign st_val_o       = val_rm_i;
  assign stall_o        = stall;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage; MUL scenarios are compiled when
// EXE_STAGE_MUL_EN is defined, otherwise code 1010 is checked as illegal.
module tb_exe_stage;
  import exe_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc;
  logic        wb_en, mem_r_en, mem_w_en;
  logic [3:0]  exe_cmd;
  logic        b, s;
  logic [31:0] val_rn, val_rm;
  logic [11:0] shift_operand;
  logic        imm;
  logic [23:0] signed_imm_24;
  logic [3:0]  dest;
  logic [31:0] alu_result, br_addr, st_val;
  logic        branch_taken, wb_en_out, mem_r_en_out, mem_w_en_out, stall;
  logic [3:0]  status, dest_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [3:0]  st_q[$];
  logic [3:0]  status_ref;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [11:0] so;
    logic        im;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[10];

  exe_stage dut (
    .clk             (clk),
    .rst             (rst),
    .pc_i            (pc),
    .wb_en_i         (wb_en),
    .mem_r_en_i      (mem_r_en),
    .mem_w_en_i      (mem_w_en),
    .exe_cmd_i       (exe_cmd),
    .b_i             (b),
    .s_i             (s),
    .val_rn_i        (val_rn),
    .val_rm_i        (val_rm),
    .shift_operand_i (shift_operand),
    .imm_i           (imm),
    .signed_imm_24_i (signed_imm_24),
    .dest_i          (dest),
    .alu_result_o    (alu_result),
    .br_addr_o       (br_addr),
    .branch_taken_o  (branch_taken),
    .status_o        (status),
    .wb_en_o         (wb_en_out),
    .mem_r_en_o      (mem_r_en_out),
    .mem_w_en_o      (mem_w_en_out),
    .dest_o          (dest_out),
    .st_val_o        (st_val),
    .stall_o         (stall)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic drive(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                       input logic [11:0] so, input logic im, input logic upd);
    exe_cmd = cmd; val_rn = rn; val_rm = rm; shift_operand = so; imm = im; s = upd;
    b = 1'b0; wb_en = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0; dest = 4'h0;
    pc = 32'h0; signed_imm_24 = 24'h0;
  endtask

  task automatic set_idle();
    drive(4'b0000, 32'h0, 32'h0, 12'h000, 1'b0, 1'b0);
  endtask

  // Reference add/sub written as true subtraction: returns {N,Z,C,V,result}.
  function automatic logic [35:0] model_addsub(input logic sub, input logic [31:0] a, input logic [31:0] bb);
    logic [32:0] r;
    logic c, v;
    if (sub) begin
      r = {1'b0, a} - {1'b0, bb};
      c = ~r[32];
      v = (a[31] != bb[31]) && (r[31] != a[31]);
    end else begin
      r = {1'b0, a} + {1'b0, bb};
      c = r[32];
      v = (a[31] == bb[31]) && (r[31] != a[31]);
    end
    return {r[31], r[31:0] == 32'h0, c, v, r[31:0]};
  endfunction

  task automatic test_reset();
    logic [3:0] e;
    set_idle();
    #2 rst = 1'b1;
    #1;
    status_ref = 4'b0000;
    st_q.push_back(status_ref);
    e = st_q.pop_front();
    n_tests++; if (status !== e) begin n_fail++; $display("FAIL reset_status: got %b expected %b", status, e); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_overflow();
    logic [31:0] e;
    logic [3:0]  es;
    @(negedge clk);
    drive(CMD_ADD, 32'h7FFF_FFFF, 32'h0, 12'h001, 1'b1, 1'b1);
    exp_q.push_back(32'h8000_0000);
    status_ref = 4'b1001;
    st_q.push_back(status_ref);
    #1 e = exp_q.pop_front();
    n_tests++; if (alu_result !== e) begin n_fail++; $display("FAIL add_ovf_result: got %h expected %h", alu_result, e); end
    @(negedge clk);
    es = st_q.pop_front();
    n_tests++; if (status !== es) begin n_fail++; $display("FAIL add_ovf_status: got %b expected %b", status, es); end
    set_idle();
  endtask

  task automatic test_cmp();
    logic [31:0] e;
    logic [3:0]  es;
    @(negedge clk);
    drive(CMD_SUB, 32'd5, 32'd5, 12'h000, 1'b0, 1'b1);
    exp_q.push_back(32'h0);
    status_ref = 4'b0110;
    st_q.push_back(status_ref);
    #1 e = exp_q.pop_front();
    n_tests++; if (alu_result !== e) begin n_fail++; $display("FAIL cmp_result: got %h expected %h", alu_result, e); end
    @(negedge clk);
    es = st_q.pop_front();
    n_tests++; if (status !== es) begin n_fail++; $display("FAIL cmp_status: got %b expected %b", status, es); end
    // Same subtraction shape with s=0 must leave the flags alone.
    drive(CMD_SUB, 32'd3, 32'd5, 12'h000, 1'b0, 1'b0);
    exp_q.push_back(32'hFFFF_FFFE);
    st_q.push_back(status_ref);
    #1 e = exp_q.pop_front();
    n_tests++; if (alu_result !== e) begin n_fail++; $display("FAIL sub_nos_result: got %h expected %h", alu_result, e); end
    @(negedge clk);
    es = st_q.pop_front();
    n_tests++; if (status !== es) begin n_fail++; $display("FAIL sub_nos_status: got %b expected %b", status, es); end
    set_idle();
  endtask

  // MVN keeps C/V, ADC consumes C=1, SBC consumes C=0.
  task automatic test_carry_chain();
    logic [31:0] e;
    logic [3:0]  es;
    logic [3:0]  cmds[3]  = '{CMD_MVN, CMD_ADC, CMD_SBC};
    logic [31:0] rns[3]   = '{32'h0, 32'd1, 32'd5};
    logic [11:0] sos[3]   = '{12'h000, 12'h001, 12'h002};
    logic [31:0] exps[3]  = '{32'hFFFF_FFFF, 32'd3, 32'd2};
    logic [3:0]  sts[3]   = '{4'b1010, 4'b0000, 4'b0010};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(cmds[i], rns[i], 32'h0, sos[i], 1'b1, 1'b1);
      exp_q.push_back(exps[i]);
      status_ref = sts[i];
      st_q.push_back(status_ref);
      #1 e = exp_q.pop_front();
      n_tests++; if (alu_result !== e) begin n_fail++; $display("FAIL carry_chain_result[%0d]: got %h expected %h", i, alu_result, e); end
      @(negedge clk);
      es = st_q.pop_front();
      n_tests++; if (status !== es) begin n_fail++; $display("FAIL carry_chain_status[%0d]: got %b expected %b", i, status, es); end
      set_idle();
    end
  endtask

  task automatic test_val2_and_logic();
    logic [31:0] e;
    vecs = '{
      '{CMD_MOV, 32'h0,         32'h0,         12'h2FF, 1'b1, 32'hF000_000F},
      '{CMD_MOV, 32'h0,         32'h0,         12'h0AB, 1'b1, 32'h0000_00AB},
      '{CMD_MOV, 32'h0,         32'h8000_0000, 12'h0C1, 1'b0, 32'hC000_0000},
      '{CMD_MOV, 32'h0,         32'h0000_000F, 12'h200, 1'b0, 32'h0000_00F0},
      '{CMD_MOV, 32'h0,         32'h0000_00F0, 12'h220, 1'b0, 32'h0000_000F},
      '{CMD_MOV, 32'h0,         32'h0000_000F, 12'h260, 1'b0, 32'hF000_0000},
      '{CMD_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 12'h000, 1'b0, 32'h0F00_0F00},
      '{CMD_ORR, 32'hFF00_FF00, 32'h0FF0_0FF0, 12'h000, 1'b0, 32'hFFF0_FFF0},
      '{CMD_EOR, 32'hFF00_FF00, 32'h0FF0_0FF0, 12'h000, 1'b0, 32'hF0F0_F0F0},
      '{4'b0000, 32'h1234_5678, 32'h1111_1111, 12'h000, 1'b0, 32'h0000_0000}
    };
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].cmd, vecs[i].rn, vecs[i].rm, vecs[i].so, vecs[i].im, 1'b0);
      exp_q.push_back(vecs[i].exp);
      #1 e = exp_q.pop_front();
      n_tests++; if (alu_result !== e) begin n_fail++; $display("FAIL vec[%0d]_result: got %h expected %h", i, alu_result, e); end
    end
    set_idle();
  endtask

  task automatic test_mem_passthrough();
    logic [31:0] e;
    @(negedge clk);
    drive(CMD_ADD, 32'h0000_1000, 32'h0000_0055, 12'hFFF, 1'b0, 1'b0);
    mem_r_en = 1'b1; wb_en = 1'b1; dest = 4'hA;
    exp_q.push_back(32'h0000_1FFF);
    #1 e = exp_q.pop_front();
    n_tests++; if (alu_result !== e) begin n_fail++; $display("FAIL mem_addr: got %h expected %h", alu_result, e); end
    n_tests++; if ({mem_r_en_out, mem_w_en_out, wb_en_out, dest_out} !== 7'b101_1010)
      begin n_fail++; $display("FAIL mem_ctrl: got %b expected 1011010", {mem_r_en_out, mem_w_en_out, wb_en_out, dest_out}); end
    n_tests++; if (st_val !== 32'h0000_0055) begin n_fail++; $display("FAIL st_val: got %h expected 00000055", st_val); end
    set_idle();
  endtask

  task automatic test_branch();
    logic [31:0] e;
    logic [3:0]  es;
    logic [31:0] pcs[2]  = '{32'h0000_0100, 32'h0000_0200};
    logic [23:0] offs[2] = '{24'hFFFFFE, 24'h000010};
    logic [31:0] tgts[2] = '{32'h0000_00F8, 32'h0000_0240};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      // ADD of zeros with s=1 would set Z if B were allowed to write flags.
      drive(CMD_ADD, 32'h0, 32'h0, 12'h000, 1'b1, 1'b1);
      b = 1'b1; pc = pcs[i]; signed_imm_24 = offs[i];
      exp_q.push_back(tgts[i]);
      st_q.push_back(status_ref);
      #1 e = exp_q.pop_front();
      n_tests++; if (br_addr !== e) begin n_fail++; $display("FAIL br_addr[%0d]: got %h expected %h", i, br_addr, e); end
      n_tests++; if (branch_taken !== 1'b1) begin n_fail++; $display("FAIL branch_taken[%0d]: got %b expected 1", i, branch_taken); end
      @(negedge clk);
      es = st_q.pop_front();
      n_tests++; if (status !== es) begin n_fail++; $display("FAIL branch_status[%0d]: got %b expected %b", i, status, es); end
      set_idle();
    end
    #1;
    n_tests++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL branch_idle: got %b expected 0", branch_taken); end
  endtask

`ifdef EXE_STAGE_MUL_EN
  task automatic test_mul();
    logic [31:0] e;
    logic [3:0]  es;
    int stall_cycles;
    @(negedge clk);
    drive(CMD_SUB, 32'd5, 32'd5, 12'h000, 1'b0, 1'b1);
    status_ref = 4'b0110;
    @(negedge clk);
    drive(CMD_MUL, 32'h0001_2345, 32'h0000_0010, 12'h000, 1'b0, 1'b1);
    wb_en = 1'b1; dest = 4'h3;
    exp_q.push_back(32'h0012_3450);
    status_ref = 4'b0010;
    st_q.push_back(status_ref);
    #1;
    stall_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (stall !== 1'b1) break;
      stall_cycles++;
      n_tests++; if (wb_en_out !== 1'b0) begin n_fail++; $display("FAIL mul_bubble[%0d]: got wb_en %b expected 0", i, wb_en_out); end
      @(negedge clk);
    end
    n_tests++; if (stall_cycles != 5) begin n_fail++; $display("FAIL mul_stall_len: got %0d expected 5", stall_cycles); end
    e = exp_q.pop_front();
    n_tests++; if (alu_result !== e) begin n_fail++; $display("FAIL mul_result: got %h expected %h", alu_result, e); end
    n_tests++; if (wb_en_out !== 1'b1) begin n_fail++; $display("FAIL mul_done_wb: got %b expected 1", wb_en_out); end
    @(negedge clk);
    set_idle();
    #1 es = st_q.pop_front();
    n_tests++; if (status !== es) begin n_fail++; $display("FAIL mul_status: got %b expected %b", status, es); end
  endtask

  task automatic test_mul_reset();
    logic [31:0] e;
    logic [3:0]  es;
    @(negedge clk);
    drive(CMD_MUL, 32'h0000_0007, 32'h0000_0009, 12'h000, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    status_ref = 4'b0000;
    st_q.push_back(status_ref);
    #1 es = st_q.pop_front();
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mulrst_stall: got %b expected 0", stall); end
    n_tests++; if (status !== es) begin n_fail++; $display("FAIL mulrst_status: got %b expected %b", status, es); end
    @(negedge clk);
    rst = 1'b0;
    drive(CMD_ADD, 32'd1, 32'h0, 12'h002, 1'b1, 1'b1);
    exp_q.push_back(32'd3);
    #1 e = exp_q.pop_front();
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mulrst_add_stall: got %b expected 0", stall); end
    n_tests++; if (alu_result !== e) begin n_fail++; $display("FAIL mulrst_add_result: got %h expected %h", alu_result, e); end
    @(negedge clk);
    set_idle();
  endtask
`else
  task automatic test_mul_disabled();
    logic [31:0] e;
    logic [3:0]  es;
    @(negedge clk);
    drive(CMD_MUL, 32'h0001_2345, 32'h0000_0010, 12'h000, 1'b0, 1'b1);
    wb_en = 1'b1;
    exp_q.push_back(32'h0);
    st_q.push_back(status_ref);
    #1 e = exp_q.pop_front();
    n_tests++; if (alu_result !== e) begin n_fail++; $display("FAIL nomul_result: got %h expected %h", alu_result, e); end
    n_tests++; if ({stall, wb_en_out} !== 2'b01) begin n_fail++; $display("FAIL nomul_stall_wb: got %b expected 01", {stall, wb_en_out}); end
    @(negedge clk);
    es = st_q.pop_front();
    n_tests++; if (status !== es) begin n_fail++; $display("FAIL nomul_status: got %b expected %b", status, es); end
    set_idle();
  endtask
`endif

  task automatic test_back_to_back();
    logic [35:0] m;
    logic        sub;
    logic [31:0] a, bb, e;
    logic [3:0]  es;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i > 0) begin
        es = st_q.pop_front();
        n_tests++; if (status !== es) begin n_fail++; $display("FAIL b2b_status[%0d]: got %b expected %b", i - 1, status, es); end
      end
      sub = 1'($urandom_range(0, 1));
      a   = $urandom;
      bb  = $urandom;
      if (i == 0) begin sub = 1'b0; a = 32'h8000_0000; bb = 32'h8000_0000; end
      if (i == 1) begin sub = 1'b1; a = 32'h8000_0000; bb = 32'h0000_0001; end
      m = model_addsub(sub, a, bb);
      drive(sub ? CMD_SUB : CMD_ADD, a, bb, 12'h000, 1'b0, 1'b1);
      exp_q.push_back(m[31:0]);
      st_q.push_back(m[35:32]);
      #1 e = exp_q.pop_front();
      n_tests++; if (alu_result !== e) begin n_fail++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, alu_result, e); end
    end
    @(negedge clk);
    es = st_q.pop_front();
    n_tests++; if (status !== es) begin n_fail++; $display("FAIL b2b_status_last: got %b expected %b", status, es); end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_cmp();
    test_carry_chain();
    test_val2_and_logic();
    test_mem_passthrough();
    test_branch();
`ifdef EXE_STAGE_MUL_EN
    test_mul();
    test_mul_reset();
`else
    test_mul_disabled();
`endif
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
